// File: rtl/tcp_tx_ptr_client_if.sv
// Bundle of the app-side pointer request/response channel and the noc0
// router port used by the TCP TX pointer client. The client itself connects
// through the master modport; whatever sits around it (app engine and
// router) connects through the slave modport.
interface tcp_tx_ptr_client_if #(
   parameter int FLOW_ID_W      = 8,
   parameter int PAYLOAD_PTR_W  = 15,
   parameter int NOC_DATA_WIDTH = 128
);
   // App request channel
   logic                       app_ptr_req_val;
   logic                       app_ptr_req_wr;
   logic [FLOW_ID_W-1:0]       app_ptr_req_flowid;
   logic [PAYLOAD_PTR_W:0]     app_ptr_req_tail;
   logic                       ptr_app_req_rdy;

   // App response channel
   logic                       ptr_app_resp_val;
   logic [FLOW_ID_W-1:0]       ptr_app_resp_flowid;
   logic [PAYLOAD_PTR_W:0]     ptr_app_resp_head;
   logic [PAYLOAD_PTR_W:0]     ptr_app_resp_tail;
   logic                       ptr_app_resp_err;
   logic                       app_ptr_resp_rdy;

   // Outbound flits toward the router
   logic                       tcp_ptr_client_noc0_vrtoc_val;
   logic [NOC_DATA_WIDTH-1:0]  tcp_ptr_client_noc0_vrtoc_data;
   logic                       noc0_vrtoc_tcp_ptr_client_rdy;

   // Inbound flits from the router
   logic                       noc0_ctovr_tcp_ptr_client_val;
   logic [NOC_DATA_WIDTH-1:0]  noc0_ctovr_tcp_ptr_client_data;
   logic                       tcp_ptr_client_noc0_ctovr_rdy;

   modport master (
      input  app_ptr_req_val, app_ptr_req_wr, app_ptr_req_flowid, app_ptr_req_tail,
      output ptr_app_req_rdy,
      output ptr_app_resp_val, ptr_app_resp_flowid, ptr_app_resp_head,
      output ptr_app_resp_tail, ptr_app_resp_err,
      input  app_ptr_resp_rdy,
      output tcp_ptr_client_noc0_vrtoc_val, tcp_ptr_client_noc0_vrtoc_data,
      input  noc0_vrtoc_tcp_ptr_client_rdy,
      input  noc0_ctovr_tcp_ptr_client_val, noc0_ctovr_tcp_ptr_client_data,
      output tcp_ptr_client_noc0_ctovr_rdy
   );

   modport slave (
      output app_ptr_req_val, app_ptr_req_wr, app_ptr_req_flowid, app_ptr_req_tail,
      input  ptr_app_req_rdy,
      input  ptr_app_resp_val, ptr_app_resp_flowid, ptr_app_resp_head,
      input  ptr_app_resp_tail, ptr_app_resp_err,
      output app_ptr_resp_rdy,
      input  tcp_ptr_client_noc0_vrtoc_val, tcp_ptr_client_noc0_vrtoc_data,
      output noc0_vrtoc_tcp_ptr_client_rdy,
      output noc0_ctovr_tcp_ptr_client_val, noc0_ctovr_tcp_ptr_client_data,
      input  tcp_ptr_client_noc0_ctovr_rdy
   );
endinterface

// File: rtl/tcp_tx_ptr_client.sv
// App-side initiator for the TCP TX pointer tile. Turns one app pointer
// request at a time into a single NoC flit; reads then wait for the matching
// response flit (or a timeout), writes are posted and return straight to idle.
module tcp_tx_ptr_client #(
   parameter logic [7:0] SRC_X          = 8'd0,
   parameter logic [7:0] SRC_Y          = 8'd0,
   parameter logic [7:0] DST_X          = 8'd1,
   parameter logic [7:0] DST_Y          = 8'd1,
   parameter int         RESP_TIMEOUT   = 1024,
   parameter int         FLOW_ID_W      = 8,
   parameter int         PAYLOAD_PTR_W  = 15,
   parameter int         NOC_DATA_WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   tcp_tx_ptr_client_if.master    bus,
   output logic [15:0]            drop_cnt
);

   localparam int PW      = PAYLOAD_PTR_W + 1;
   localparam int W       = NOC_DATA_WIDTH;
   localparam int FID_HI  = W - 49;
   localparam int HEAD_HI = FID_HI - FLOW_ID_W;
   localparam int TAIL_HI = HEAD_HI - PW;
   localparam int TIMER_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;

   localparam logic [7:0] MSG_RD_REQ  = 8'h10;
   localparam logic [7:0] MSG_WR_REQ  = 8'h11;
   localparam logic [7:0] MSG_RD_RESP = 8'h12;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic                  r_wr;
   logic [FLOW_ID_W-1:0]  r_flowid;
   logic [PW-1:0]         r_tailReq;
   logic [TIMER_W-1:0]    r_timer;
   logic [PW-1:0]         r_respHead;
   logic [PW-1:0]         r_respTail;
   logic                  r_respErr;
   logic [15:0]           r_dropCnt;

   logic                  w_reqRdy;
   logic                  w_txVal;
   logic                  w_rxRdy;
   logic                  w_respVal;
   logic                  w_match;
   logic                  w_timeout;
   logic [W-1:0]          w_txFlit;
   logic                  w_unusedBits;

   // A response belongs to us only if it is a read response for the flow we asked about
   assign w_match   = (bus.noc0_ctovr_tcp_ptr_client_data[W-33 -: 8] == MSG_RD_RESP) &&
                      (bus.noc0_ctovr_tcp_ptr_client_data[FID_HI -: FLOW_ID_W] == r_flowid);
   assign w_timeout = (r_timer == TIMER_W'(RESP_TIMEOUT - 1));
   assign w_unusedBits = ^bus.noc0_ctovr_tcp_ptr_client_data;

   // State register; a reset abandons whatever request was in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs, all decoded from state alone
   always_comb begin
      w_nextState = r_state;
      w_reqRdy    = 1'b0;
      w_txVal     = 1'b0;
      w_rxRdy     = 1'b0;
      w_respVal   = 1'b0;
      case (r_state)
         IDLE: begin
            w_reqRdy = 1'b1;
            if (bus.app_ptr_req_val) w_nextState = SEND;
         end
         SEND: begin
            w_txVal = 1'b1;
            if (bus.noc0_vrtoc_tcp_ptr_client_rdy) w_nextState = r_wr ? IDLE : WAIT;
         end
         WAIT: begin
            w_rxRdy = 1'b1;
            if ((bus.noc0_ctovr_tcp_ptr_client_val && w_match) || w_timeout) w_nextState = RESP;
         end
         RESP: begin
            w_respVal = 1'b1;
            if (bus.app_ptr_resp_rdy) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Request capture, response timer, response latching and drop counting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr       <= 1'b0;
         r_flowid   <= '0;
         r_tailReq  <= '0;
         r_timer    <= '0;
         r_respHead <= '0;
         r_respTail <= '0;
         r_respErr  <= 1'b0;
         r_dropCnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.app_ptr_req_val) begin
                  r_wr      <= bus.app_ptr_req_wr;
                  r_flowid  <= bus.app_ptr_req_flowid;
                  r_tailReq <= bus.app_ptr_req_tail;
               end
            end
            SEND: begin
               if (bus.noc0_vrtoc_tcp_ptr_client_rdy) r_timer <= '0;
            end
            WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (bus.noc0_ctovr_tcp_ptr_client_val && w_match) begin
                  r_respHead <= bus.noc0_ctovr_tcp_ptr_client_data[HEAD_HI -: PW];
                  r_respTail <= bus.noc0_ctovr_tcp_ptr_client_data[TAIL_HI -: PW];
                  r_respErr  <= 1'b0;
               end else begin
                  if (bus.noc0_ctovr_tcp_ptr_client_val && (r_dropCnt != 16'hFFFF)) begin
                     r_dropCnt <= r_dropCnt + 16'd1;
                  end
                  if (w_timeout) begin
                     r_respHead <= '0;
                     r_respTail <= '0;
                     r_respErr  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outbound flit is built purely from captured registers so it stays stable under back-pressure
   always_comb begin
      w_txFlit                     = '0;
      w_txFlit[W-1 -: 8]           = DST_X;
      w_txFlit[W-9 -: 8]           = DST_Y;
      w_txFlit[W-17 -: 8]          = SRC_X;
      w_txFlit[W-25 -: 8]          = SRC_Y;
      w_txFlit[W-33 -: 8]          = r_wr ? MSG_WR_REQ : MSG_RD_REQ;
      w_txFlit[W-41 -: 8]          = 8'h00;
      w_txFlit[FID_HI -: FLOW_ID_W] = r_flowid;
      w_txFlit[TAIL_HI -: PW]      = r_wr ? r_tailReq : '0;
   end

   assign bus.ptr_app_req_rdy                = w_reqRdy;
   assign bus.tcp_ptr_client_noc0_vrtoc_val  = w_txVal;
   assign bus.tcp_ptr_client_noc0_vrtoc_data = w_txFlit;
   assign bus.tcp_ptr_client_noc0_ctovr_rdy  = w_rxRdy;
   assign bus.ptr_app_resp_val               = w_respVal;
   assign bus.ptr_app_resp_flowid            = r_flowid;
   assign bus.ptr_app_resp_head              = r_respHead;
   assign bus.ptr_app_resp_tail              = r_respTail;
   assign bus.ptr_app_resp_err               = r_respErr;
   assign drop_cnt                           = r_dropCnt;

endmodule

// File: tb/tb_tcp_tx_ptr_client.sv
// Directed bench for the TCP TX pointer client: read, posted write,
// request back-pressure, unexpected-flit dropping, timeout, the
// match/timeout race and reset in the middle of a read.
module tb_tcp_tx_ptr_client;

   localparam logic [7:0] SRC_X = 8'h02;
   localparam logic [7:0] SRC_Y = 8'h03;
   localparam logic [7:0] DST_X = 8'h04;
   localparam logic [7:0] DST_Y = 8'h05;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dropCnt;
   int          passCnt = 0;
   int          checkCnt = 0;

   tcp_tx_ptr_client_if #(.FLOW_ID_W(8), .PAYLOAD_PTR_W(15), .NOC_DATA_WIDTH(128)) bus ();

   tcp_tx_ptr_client #(
      .SRC_X(SRC_X), .SRC_Y(SRC_Y), .DST_X(DST_X), .DST_Y(DST_Y),
      .RESP_TIMEOUT(16), .FLOW_ID_W(8), .PAYLOAD_PTR_W(15), .NOC_DATA_WIDTH(128)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.master),
      .drop_cnt (dropCnt)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Flit layout for W=128, 8-bit flow id, 16-bit pointers, written out by hand
   function automatic logic [127:0] mkFlit(input logic [7:0] dx, input logic [7:0] dy,
                                           input logic [7:0] sx, input logic [7:0] sy,
                                           input logic [7:0] mtype, input logic [7:0] fid,
                                           input logic [15:0] head, input logic [15:0] tail);
      logic [127:0] f;
      f = '0;
      f[127:120] = dx;
      f[119:112] = dy;
      f[111:104] = sx;
      f[103:96]  = sy;
      f[95:88]   = mtype;
      f[87:80]   = 8'h00;
      f[79:72]   = fid;
      f[71:56]   = head;
      f[55:40]   = tail;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issueReq(input logic wr, input logic [7:0] fid, input logic [15:0] tail);
      bus.app_ptr_req_val    = 1'b1;
      bus.app_ptr_req_wr     = wr;
      bus.app_ptr_req_flowid = fid;
      bus.app_ptr_req_tail   = tail;
      tick();
      bus.app_ptr_req_val    = 1'b0;
      bus.app_ptr_req_wr     = 1'b0;
      bus.app_ptr_req_flowid = '0;
      bus.app_ptr_req_tail   = '0;
   endtask

   task automatic respond(input logic [127:0] flit);
      bus.noc0_ctovr_tcp_ptr_client_val  = 1'b1;
      bus.noc0_ctovr_tcp_ptr_client_data = flit;
      tick();
      bus.noc0_ctovr_tcp_ptr_client_val  = 1'b0;
      bus.noc0_ctovr_tcp_ptr_client_data = '0;
   endtask

   task automatic finishResp();
      bus.app_ptr_resp_rdy = 1'b1;
      tick();
      bus.app_ptr_resp_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkCnt++; if (bus.ptr_app_req_rdy !== 1'b1) $display("[TB] FAIL reset_req_rdy: got %b want 1", bus.ptr_app_req_rdy); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_vrtoc_val !== 1'b0) $display("[TB] FAIL reset_vrtoc_val: got %b want 0", bus.tcp_ptr_client_noc0_vrtoc_val); else passCnt++;
      checkCnt++; if (bus.ptr_app_resp_val !== 1'b0) $display("[TB] FAIL reset_resp_val: got %b want 0", bus.ptr_app_resp_val); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_ctovr_rdy !== 1'b0) $display("[TB] FAIL reset_ctovr_rdy: got %b want 0", bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      checkCnt++; if (dropCnt !== 16'd0) $display("[TB] FAIL reset_drop_cnt: got %0d want 0", dropCnt); else passCnt++;
      checkCnt++; if ({bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err} !== 33'd0)
         $display("[TB] FAIL reset_resp_regs: got %h/%h/%b want 0/0/0", bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err); else passCnt++;
   endtask

   task automatic test_read();
      logic [127:0] expFlit;
      expFlit = mkFlit(DST_X, DST_Y, SRC_X, SRC_Y, 8'h10, 8'd5, 16'h0, 16'h0);
      issueReq(1'b0, 8'd5, 16'h0);
      checkCnt++; if (bus.ptr_app_req_rdy !== 1'b0) $display("[TB] FAIL read_rdy_in_send: got %b want 0", bus.ptr_app_req_rdy); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_vrtoc_val !== 1'b1) $display("[TB] FAIL read_vrtoc_val: got %b want 1", bus.tcp_ptr_client_noc0_vrtoc_val); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_vrtoc_data !== expFlit) $display("[TB] FAIL read_flit: got %h want %h", bus.tcp_ptr_client_noc0_vrtoc_data, expFlit); else passCnt++;
      tick();
      checkCnt++; if (bus.tcp_ptr_client_noc0_ctovr_rdy !== 1'b1) $display("[TB] FAIL read_wait_ctovr_rdy: got %b want 1", bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd5, 16'h0100, 16'h0180));
      checkCnt++; if (bus.ptr_app_resp_val !== 1'b1) $display("[TB] FAIL read_resp_val: got %b want 1", bus.ptr_app_resp_val); else passCnt++;
      checkCnt++; if ({bus.ptr_app_resp_flowid, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err} !== {8'd5, 16'h0100, 16'h0180, 1'b0})
         $display("[TB] FAIL read_resp_fields: got %h/%h/%h/%b want 05/0100/0180/0", bus.ptr_app_resp_flowid, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_ctovr_rdy !== 1'b0) $display("[TB] FAIL read_resp_ctovr_rdy: got %b want 0", bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      tick();
      checkCnt++; if ({bus.ptr_app_resp_val, bus.ptr_app_resp_head} !== {1'b1, 16'h0100}) $display("[TB] FAIL read_resp_hold: got %b/%h want 1/0100", bus.ptr_app_resp_val, bus.ptr_app_resp_head); else passCnt++;
      finishResp();
      checkCnt++; if ({bus.ptr_app_req_rdy, bus.ptr_app_resp_val} !== 2'b10) $display("[TB] FAIL read_back_idle: got rdy %b val %b want 1 0", bus.ptr_app_req_rdy, bus.ptr_app_resp_val); else passCnt++;
   endtask

   task automatic test_write();
      logic [127:0] expFlit;
      expFlit = mkFlit(DST_X, DST_Y, SRC_X, SRC_Y, 8'h11, 8'd3, 16'h0, 16'h0040);
      issueReq(1'b1, 8'd3, 16'h0040);
      checkCnt++; if (bus.tcp_ptr_client_noc0_vrtoc_val !== 1'b1) $display("[TB] FAIL write_vrtoc_val: got %b want 1", bus.tcp_ptr_client_noc0_vrtoc_val); else passCnt++;
      checkCnt++; if (bus.tcp_ptr_client_noc0_vrtoc_data !== expFlit) $display("[TB] FAIL write_flit: got %h want %h", bus.tcp_ptr_client_noc0_vrtoc_data, expFlit); else passCnt++;
      tick();
      checkCnt++; if ({bus.ptr_app_req_rdy, bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_ctovr_rdy} !== 3'b100)
         $display("[TB] FAIL write_back_idle: got rdy %b val %b ctovr_rdy %b want 1 0 0", bus.ptr_app_req_rdy, bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      tick();
      checkCnt++; if (bus.ptr_app_resp_val !== 1'b0) $display("[TB] FAIL write_no_resp: got %b want 0", bus.ptr_app_resp_val); else passCnt++;
   endtask

   task automatic test_backpressure();
      logic [127:0] expFlit;
      expFlit = mkFlit(DST_X, DST_Y, SRC_X, SRC_Y, 8'h10, 8'd6, 16'h0, 16'h0);
      bus.noc0_vrtoc_tcp_ptr_client_rdy = 1'b0;
      issueReq(1'b0, 8'd6, 16'h0);
      for (int i = 0; i < 10; i++) begin
         checkCnt++; if ({bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_vrtoc_data} !== {1'b1, expFlit})
            $display("[TB] FAIL bp_hold_%0d: got %b/%h want 1/%h", i, bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_vrtoc_data, expFlit); else passCnt++;
         tick();
      end
      bus.noc0_vrtoc_tcp_ptr_client_rdy = 1'b1;
      tick();
      checkCnt++; if ({bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_ctovr_rdy} !== 2'b01)
         $display("[TB] FAIL bp_single_accept: got val %b ctovr_rdy %b want 0 1", bus.tcp_ptr_client_noc0_vrtoc_val, bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd6, 16'h0011, 16'h0022));
      checkCnt++; if ({bus.ptr_app_resp_val, bus.ptr_app_resp_head, bus.ptr_app_resp_tail} !== {1'b1, 16'h0011, 16'h0022})
         $display("[TB] FAIL bp_resp: got %b/%h/%h want 1/0011/0022", bus.ptr_app_resp_val, bus.ptr_app_resp_head, bus.ptr_app_resp_tail); else passCnt++;
      finishResp();
   endtask

   task automatic test_drop();
      issueReq(1'b0, 8'd5, 16'h0);
      tick();
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd7, 16'h0999, 16'h0999));
      checkCnt++; if ({dropCnt, bus.ptr_app_resp_val, bus.tcp_ptr_client_noc0_ctovr_rdy} !== {16'd1, 1'b0, 1'b1})
         $display("[TB] FAIL drop_wrong_flow: got cnt %0d val %b rdy %b want 1 0 1", dropCnt, bus.ptr_app_resp_val, bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h10, 8'd5, 16'h0888, 16'h0888));
      checkCnt++; if ({dropCnt, bus.ptr_app_resp_val} !== {16'd2, 1'b0})
         $display("[TB] FAIL drop_wrong_type: got cnt %0d val %b want 2 0", dropCnt, bus.ptr_app_resp_val); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd5, 16'h0022, 16'h0033));
      checkCnt++; if ({bus.ptr_app_resp_val, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, dropCnt} !== {1'b1, 16'h0022, 16'h0033, 16'd2})
         $display("[TB] FAIL drop_then_match: got %b/%h/%h cnt %0d want 1/0022/0033 cnt 2", bus.ptr_app_resp_val, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, dropCnt); else passCnt++;
      finishResp();
   endtask

   task automatic test_timeout();
      int n;
      issueReq(1'b0, 8'd1, 16'h0);
      tick();
      n = 0;
      while (bus.ptr_app_resp_val !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checkCnt++; if (n !== 16) $display("[TB] FAIL timeout_latency: got %0d cycles want 16", n); else passCnt++;
      checkCnt++; if ({bus.ptr_app_resp_err, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_flowid} !== {1'b1, 16'h0, 16'h0, 8'd1})
         $display("[TB] FAIL timeout_resp: got err %b %h/%h flow %h want 1 0000/0000 01", bus.ptr_app_resp_err, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_flowid); else passCnt++;
      finishResp();
   endtask

   task automatic test_timeout_race();
      logic early;
      early = 1'b0;
      issueReq(1'b0, 8'd2, 16'h0);
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.ptr_app_resp_val !== 1'b0) early = 1'b1;
      end
      checkCnt++; if (early !== 1'b0) $display("[TB] FAIL race_early_resp: got %b want 0", early); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd2, 16'h1234, 16'h5678));
      checkCnt++; if ({bus.ptr_app_resp_val, bus.ptr_app_resp_err, bus.ptr_app_resp_head, bus.ptr_app_resp_tail} !== {1'b1, 1'b0, 16'h1234, 16'h5678})
         $display("[TB] FAIL race_match_wins: got %b err %b %h/%h want 1 0 1234/5678", bus.ptr_app_resp_val, bus.ptr_app_resp_err, bus.ptr_app_resp_head, bus.ptr_app_resp_tail); else passCnt++;
      finishResp();
   endtask

   task automatic test_reset_in_wait();
      issueReq(1'b0, 8'd5, 16'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkCnt++; if ({bus.ptr_app_req_rdy, bus.tcp_ptr_client_noc0_vrtoc_val, dropCnt} !== {1'b1, 1'b0, 16'd0})
         $display("[TB] FAIL rst_wait_idle: got rdy %b val %b cnt %0d want 1 0 0", bus.ptr_app_req_rdy, bus.tcp_ptr_client_noc0_vrtoc_val, dropCnt); else passCnt++;
      bus.noc0_ctovr_tcp_ptr_client_val  = 1'b1;
      bus.noc0_ctovr_tcp_ptr_client_data = mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd5, 16'h0AAA, 16'h0BBB);
      checkCnt++; if (bus.tcp_ptr_client_noc0_ctovr_rdy !== 1'b0) $display("[TB] FAIL rst_stale_bp: got %b want 0", bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      tick();
      issueReq(1'b0, 8'd9, 16'h0);
      checkCnt++; if (bus.tcp_ptr_client_noc0_ctovr_rdy !== 1'b0) $display("[TB] FAIL rst_send_bp: got %b want 0", bus.tcp_ptr_client_noc0_ctovr_rdy); else passCnt++;
      tick();
      tick();
      checkCnt++; if ({dropCnt, bus.ptr_app_resp_val} !== {16'd1, 1'b0})
         $display("[TB] FAIL rst_stale_dropped: got cnt %0d val %b want 1 0", dropCnt, bus.ptr_app_resp_val); else passCnt++;
      respond(mkFlit(SRC_X, SRC_Y, DST_X, DST_Y, 8'h12, 8'd9, 16'h0055, 16'h0066));
      checkCnt++; if ({bus.ptr_app_resp_val, bus.ptr_app_resp_flowid, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err} !== {1'b1, 8'd9, 16'h0055, 16'h0066, 1'b0})
         $display("[TB] FAIL rst_new_resp: got %b %h %h/%h err %b want 1 09 0055/0066 0", bus.ptr_app_resp_val, bus.ptr_app_resp_flowid, bus.ptr_app_resp_head, bus.ptr_app_resp_tail, bus.ptr_app_resp_err); else passCnt++;
      finishResp();
   endtask

   // Scenario sequence
   initial begin
      bus.app_ptr_req_val                = 1'b0;
      bus.app_ptr_req_wr                 = 1'b0;
      bus.app_ptr_req_flowid             = '0;
      bus.app_ptr_req_tail               = '0;
      bus.app_ptr_resp_rdy               = 1'b0;
      bus.noc0_vrtoc_tcp_ptr_client_rdy  = 1'b1;
      bus.noc0_ctovr_tcp_ptr_client_val  = 1'b0;
      bus.noc0_ctovr_tcp_ptr_client_data = '0;
      test_reset();
      test_read();
      test_write();
      test_backpressure();
      test_drop();
      test_timeout();
      test_timeout_race();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
